// File: rtl/i2c_frame_receiver_if.sv
// rtl/i2c_frame_receiver_if.sv - SCL input and received-write outputs of the I2C frame receiver
interface i2c_frame_receiver_if;
  logic       i_SCL;
  logic [7:0] o_register_addr;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;

  modport slave (
    input  i_SCL,
    output o_register_addr,
    output o_data,
    output o_valid,
    output o_busy
  );

  modport master (
    output i_SCL,
    input  o_register_addr,
    input  o_data,
    input  o_valid,
    input  o_busy
  );
endinterface

// File: rtl/i2c_frame_receiver.sv
// rtl/i2c_frame_receiver.sv - I2C target receiving single-register write frames
// Optional I2C_RX_AUTOINC_EN: keep accepting data bytes with auto-incremented register address.
module i2c_frame_receiver #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  inout  wire                   io_SDA,
  i2c_frame_receiver_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       sda_low_q, sda_low_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  // Synchronizers reset to the idle-bus level so no spurious edge follows reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= bus.i_SCL;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= io_SDA;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign byte_in   = {shift_q[6:0], sda_s2_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'h00;
      reg_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      reg_q     <= reg_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sda_low_q <= sda_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    reg_d     = reg_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    sda_low_d = sda_low_q;

    if (stop_det) begin
      state_d   = IDLE;
      cnt_d     = 3'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = DEV;
      cnt_d     = 3'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        DEV, REG, DATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == DEV) begin
                state_d = (byte_in[7:1] == DEV_ADDR && !byte_in[0]) ? ACK_DEV : IGNORE;
              end else if (state_q == REG) begin
                reg_d   = byte_in;
                state_d = ACK_REG;
              end else begin
                addr_d  = reg_q;
                data_d  = byte_in;
                valid_d = 1'b1;
                state_d = ACK_DATA;
              end
            end
          end
        end
        // First SCL fall ends the 8th bit and starts the pull-low; the next ends the ACK clock
        ACK_DEV, ACK_REG, ACK_DATA: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 3'd0;
              if (state_q == ACK_DEV) begin
                state_d = REG;
              end else if (state_q == ACK_REG) begin
                state_d = DATA;
              end else begin
`ifdef I2C_RX_AUTOINC_EN
                reg_d   = reg_q + 8'd1;
                state_d = DATA;
`else
                state_d = IGNORE;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_SDA              = sda_low_q ? 1'b0 : 1'bz;
  assign bus.o_register_addr = addr_q;
  assign bus.o_data          = data_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_busy          = busy_q;

endmodule

// File: tb/tb_i2c_frame_receiver.sv
// tb/tb_i2c_frame_receiver.sv - directed and randomized write frames checked against a frame-level model
module tb_i2c_frame_receiver;
  localparam int Q = 60;
  localparam logic [7:0] ADDR_W = 8'h78;
`ifdef I2C_RX_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic m_low;
  wire  sda_bus;

  i2c_frame_receiver_if bus_if ();

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_frame_receiver #(.DEV_ADDR(7'h3C)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_SDA  (sda_bus),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int dut_low = 0;
  int width_err = 0;
  logic [15:0] vq[$];
  logic [7:0] frm[$];
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    #2;
    if (!m_low && sda_bus == 1'b0) dut_low++;
    if (bus_if.o_valid) begin
      vq.push_back({bus_if.o_register_addr, bus_if.o_data});
      if (prev_valid) width_err++;
    end
    prev_valid = bus_if.o_valid;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i];
      #Q; bus_if.i_SCL = 1'b1;
      #(2*Q); bus_if.i_SCL = 1'b0;
      #Q;
    end
  endtask

  task automatic ack9(output bit a);
    m_low = 1'b0;
    #Q; bus_if.i_SCL = 1'b1;
    #Q; a = (sda_bus == 1'b0);
    #Q; bus_if.i_SCL = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit a);
    send_bits(b, 8);
    ack9(a);
  endtask

  task automatic i2c_start();
    m_low = 1'b1;
    #Q; bus_if.i_SCL = 1'b0;
    #Q;
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0;
    #Q; bus_if.i_SCL = 1'b1;
    #Q; m_low = 1'b1;
    #Q; bus_if.i_SCL = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #Q; bus_if.i_SCL = 1'b1;
    #Q; m_low = 1'b0;
    #(2*Q);
  endtask

  // Model: a frame is accepted iff byte 0 is our write address; byte 1 is the register,
  // each later accepted byte produces (register + k - 2, byte k)
  task automatic do_frame(input string name);
    bit ok, a, exp_ack;
    int n;
    logic [15:0] exp_q[$];
    n = frm.size();
    ok = (n > 0) && (frm[0] == ADDR_W);
    vq.delete();
    dut_low = 0;
    width_err = 0;
    i2c_start();
    chk({name, ":busy_after_start"}, bus_if.o_busy, 1);
    for (int k = 0; k < n; k++) begin
      send_byte(frm[k], a);
      exp_ack = ok && (k < 3 || AUTOINC);
      chk($sformatf("%s:ack%0d", name, k), a, exp_ack);
      if (ok && k >= 2 && (k == 2 || AUTOINC))
        exp_q.push_back({8'(frm[1] + 8'(k - 2)), frm[k]});
    end
    chk({name, ":busy_before_stop"}, bus_if.o_busy, 1);
    i2c_stop();
    chk({name, ":busy_after_stop"}, bus_if.o_busy, 0);
    chk({name, ":sda_driven"}, dut_low != 0, ok && n > 0);
    chk({name, ":valid_count"}, vq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < vq.size(); i++)
      chk($sformatf("%s:pair%0d", name, i), vq[i], exp_q[i]);
    chk({name, ":valid_width"}, width_err, 0);
    if (exp_q.size() > 0) begin
      last_addr = exp_q[exp_q.size()-1][15:8];
      last_data = exp_q[exp_q.size()-1][7:0];
    end
    chk({name, ":hold_addr"}, bus_if.o_register_addr, last_addr);
    chk({name, ":hold_data"}, bus_if.o_data, last_data);
  endtask

  initial begin
    bit a;
    m_low = 1'b0;
    bus_if.i_SCL = 1'b1;
    rst_n = 1'b0;
    #(2*Q);
    chk("rst:sda", sda_bus, 1);
    chk("rst:addr", bus_if.o_register_addr, 0);
    chk("rst:data", bus_if.o_data, 0);
    chk("rst:valid", bus_if.o_valid, 0);
    chk("rst:busy", bus_if.o_busy, 0);
    rst_n = 1'b1;
    #(2*Q);

    frm = '{8'h78, 8'hFF, 8'hFE};              do_frame("basic");
    frm = '{8'h7A, 8'h12, 8'h34};              do_frame("wrong_addr");
    frm = '{8'h79, 8'h12, 8'h34};              do_frame("read_bit");
    frm = '{8'h78, 8'hFE, 8'h11, 8'h22, 8'h33}; do_frame("multi");

    // Repeated start: first frame abandoned after its register byte
    vq.delete();
    i2c_start();
    send_byte(8'h78, a); chk("rs:ack_dev1", a, 1);
    send_byte(8'h10, a); chk("rs:ack_reg1", a, 1);
    i2c_rstart();
    send_byte(8'h78, a); chk("rs:ack_dev2", a, 1);
    send_byte(8'h20, a); chk("rs:ack_reg2", a, 1);
    send_byte(8'h55, a); chk("rs:ack_data", a, 1);
    i2c_stop();
    chk("rs:valid_count", vq.size(), 1);
    if (vq.size() > 0) chk("rs:pair", vq[0], 16'h2055);
    last_addr = 8'h20; last_data = 8'h55;

    // STOP in the middle of the data byte
    vq.delete();
    i2c_start();
    send_byte(8'h78, a);
    send_byte(8'h33, a);
    send_bits(8'hC3, 4);
    i2c_stop();
    chk("abort:valid_count", vq.size(), 0);
    chk("abort:busy", bus_if.o_busy, 0);
    chk("abort:hold_data", bus_if.o_data, last_data);

    // Reset asserted while the target is pulling SDA for the register-byte ACK
    i2c_start();
    send_byte(8'h78, a);
    send_bits(8'h10, 8);
    m_low = 1'b0;
    #Q; bus_if.i_SCL = 1'b1;
    #Q; chk("rstack:driven", sda_bus, 0);
    rst_n = 1'b0;
    #1;
    chk("rstack:released", sda_bus, 1);
    chk("rstack:addr", bus_if.o_register_addr, 0);
    chk("rstack:busy", bus_if.o_busy, 0);
    #(Q-1);
    rst_n = 1'b1;
    bus_if.i_SCL = 1'b0;
    #Q; bus_if.i_SCL = 1'b1;
    #Q;
    last_addr = 8'h00; last_data = 8'h00;
    frm = '{8'h78, 8'h01, 8'hA5};              do_frame("after_reset");

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 5);
      frm.delete();
      frm.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR_W);
      for (int k = 1; k < n; k++) frm.push_back(8'($urandom));
      do_frame($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/i2c_frame_receiver.md
# i2c_frame_receiver

I2C target (slave) that receives single-register write frames from the team's I2C frame master: START, device address + W, register address, data, STOP. It decodes SDA/SCL sampled on the system clock, acknowledges matching bytes by pulling SDA low, and presents each received register/data pair on a one-cycle strobe. It sits on the far end of the same two-wire bus as the master and feeds on-chip register files.

## Interface
- DEV_ADDR, 7'h3C: 7-bit target address this block answers to.
- i_clk  in  1  system clock; must be ≥10× SCL frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_SCL  in  1  I2C clock from master; asynchronous to i_clk.
- io_SDA  inout  1  I2C data; open-drain: drives 0 or 1'bz, never 1.
- o_register_addr  out  8  register address of the last accepted write.
- o_data  out  8  data byte of the last accepted write.
- o_valid  out  1  one-cycle pulse: o_register_addr/o_data updated.
- o_busy  out  1  high from detected START to detected STOP.

## Operation
- i_SCL and io_SDA each pass through a 2-flop synchronizer; one further register gives previous values for edge detection.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both recognised in any state.
- Bits are sampled on detected SCL rising edges, MSB first, into an 8-bit shift register; bit counter 0..7.
- States: IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, IGNORE.
- IDLE → DEV on START. START in any other state (repeated start) → DEV, counter cleared, SDA released.
- DEV: after 8 bits, if byte[7:1]==DEV_ADDR and byte[0]==0 → ACK_DEV; otherwise → IGNORE (no ACK; reads are not supported).
- ACK_DEV → REG; REG after 8 bits → ACK_REG, register byte latched internally; ACK_REG → DATA.
- DATA after 8 bits → ACK_DATA; o_register_addr/o_data loaded, o_valid pulsed.
- ACK_DATA → IGNORE (default build; see Configuration).
- IGNORE: SDA released; waits for STOP or START.
- STOP in any state → IDLE, SDA released, o_busy low.
- ACK drive: SDA pulled low from the first SCL falling edge after the 8th bit of an accepted byte until the next SCL falling edge (end of 9th clock). Data is not sampled during the ACK clock.
- A STOP or START appearing mid-byte aborts the frame; no o_valid for an incomplete frame.

## Timing
- Reset values: io_SDA = z, o_register_addr = 0, o_data = 0, o_valid = 0, o_busy = 0, state IDLE. Asynchronous reset releases SDA immediately, including mid-ACK.
- Input latency: pin change to internal edge detect = 3 i_clk cycles.
- o_valid asserts on the i_clk cycle after the 8th data-bit SCL rising edge is detected; exactly 1 cycle wide. Outputs hold until the next o_valid.
- SDA pull-low begins within 1 cycle of the detected SCL falling edge, well inside SCL low time given the ≥10× clock ratio.
- o_busy rises the cycle after START detect and falls the cycle after STOP detect.

## Configuration
- I2C_RX_AUTOINC_EN defined: after ACK_DATA, return to DATA; each further byte is ACKed, register address increments by 1 (8-bit wrap, 0xFF → 0x00), and o_valid pulses per byte with the incremented address.
- Not defined: only one data byte per frame; ACK_DATA → IGNORE, further bytes NACKed (SDA released) with no o_valid.

## Test plan
- Write frame 0x78, 0xFF, 0xFE, STOP → ACK on all three 9th clocks; one o_valid with o_register_addr=0xFF, o_data=0xFE; o_busy low after STOP.
- Address 0x7A (wrong address) + two bytes → SDA never driven low, no o_valid, o_busy high until STOP.
- Address 0x79 (read bit) → NACK, block in IGNORE, no SDA drive for rest of frame.
- Frame 0x78, 0x10, repeated START, 0x78, 0x20, 0x55, STOP → single o_valid, register 0x20, data 0x55.
- i_rst_n low during ACK of register byte → io_SDA z immediately; after release, next full frame 0x78, 0x01, 0xA5 is received correctly.
- With I2C_RX_AUTOINC_EN: 0x78, 0xFE, 0x11, 0x22, 0x33 → three o_valid: (0xFE,0x11), (0xFF,0x22), (0x00,0x33); without macro: one o_valid, bytes 2-3 NACKed.
